// File: rtl/mult_control.sv
// mult_control: sequencing controller for a shift-add multiplier datapath (mult/multu).
//
// Runs one multiply as LOAD, then WIDTH pairs of TEST/SHIFT, then DONE. In TEST the
// datapath adds the multiplicand when the multiplier LSB is set. For a signed multiply,
// the final iteration subtracts instead, because the multiplier MSB has negative weight.
//
// Parameters:
//   WIDTH  operand width, which is also the number of add/shift iterations
//   CNT_W  iteration counter width; must be able to hold the value WIDTH
//
// Ports:
//   Clk     in   system clock, rising-edge active
//   Reset   in   asynchronous, active-high reset
//   Start   in   multiply request; honoured only in IDLE
//   Signed  in   1 = signed (mult), 0 = unsigned (multu); sampled in LOAD
//   Lsb     in   current LSB of the datapath product/multiplier register
//   Busy    out  high in LOAD, TEST and SHIFT
//   Load    out  datapath: load operands, clear product high half
//   Add     out  datapath: product_hi <= product_hi + multiplicand
//   Sub     out  datapath: product_hi <= product_hi - multiplicand
//   Shift   out  datapath: shift product register right by one
//   Done    out  one-cycle completion pulse; product valid
//   Count   out  iterations completed

module mult_control #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Signed,
  input  logic             Lsb,
  output logic             Busy,
  output logic             Load,
  output logic             Add,
  output logic             Sub,
  output logic             Shift,
  output logic             Done,
  output logic [CNT_W-1:0] Count
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StTest,
    StShift,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic             signed_q;
  logic [CNT_W-1:0] count_q;
  logic             last_iter;

  // Count still holds the index of the iteration in progress during TEST and SHIFT.
  assign last_iter = (count_q == CNT_W'(WIDTH - 1));
  assign Count     = count_q;

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Iteration counter and latched signedness
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_q  <= '0;
      signed_q <= 1'b0;
    end else begin
      case (state_q)
        StLoad: begin
          count_q  <= '0;
          signed_q <= Signed;
        end
        StShift: count_q <= count_q + CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (Start) state_d = StLoad;
      StLoad:  state_d = StTest;
      StTest:  state_d = StShift;
      StShift: state_d = last_iter ? StDone : StTest;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs; Add/Sub depend on Lsb combinationally within TEST.
  always_comb begin
    Busy  = 1'b0;
    Load  = 1'b0;
    Add   = 1'b0;
    Sub   = 1'b0;
    Shift = 1'b0;
    Done  = 1'b0;
    case (state_q)
      StLoad: begin
        Busy = 1'b1;
        Load = 1'b1;
      end
      StTest: begin
        Busy = 1'b1;
        if (Lsb && signed_q && last_iter) begin
          Sub = 1'b1;
        end else if (Lsb) begin
          Add = 1'b1;
        end
      end
      StShift: begin
        Busy  = 1'b1;
        Shift = 1'b1;
      end
      StDone:  Done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_control.sv
// Testbench for mult_control. One WIDTH=4 instance is checked cycle by cycle against an
// expected-output scoreboard. One WIDTH=32 instance drives a behavioural shift-add
// datapath, and its products and latencies are scoreboarded.

module tb_mult_control;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- WIDTH=4 instance
  logic       start4 = 1'b0, signed4 = 1'b0, lsb4 = 1'b0;
  logic       busy4, load4, add4, sub4, shift4, done4;
  logic [2:0] count4;

  mult_control #(.WIDTH(4), .CNT_W(3)) dut4 (
    .Clk   (clk),
    .Reset (rst),
    .Start (start4),
    .Signed(signed4),
    .Lsb   (lsb4),
    .Busy  (busy4),
    .Load  (load4),
    .Add   (add4),
    .Sub   (sub4),
    .Shift (shift4),
    .Done  (done4),
    .Count (count4)
  );

  // Expected vector per cycle: {busy, load, add, sub, shift, done, count[2:0]}
  logic [8:0] exp_q[$];
  string      tag_q[$];
  logic [8:0] mon_e;
  string      mon_t;

  always @(negedge clk) begin
    #2;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      check_eq(mon_t, 64'({busy4, load4, add4, sub4, shift4, done4, count4}), 64'(mon_e));
    end
  end

  task automatic step4(input logic st, input logic sg, input logic lb, input logic [8:0] e,
                       input string tag);
    @(negedge clk);
    start4  = st;
    signed4 = sg;
    lsb4    = lb;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic idle4(input int n, input logic [2:0] cnt);
    for (int i = 0; i < n; i++) step4(1'b0, 1'b0, 1'b1, {6'b000000, cnt}, "idle");
  endtask

  // One operation: the IDLE cycle with Start high, LOAD, four TEST/SHIFT pairs, and DONE.
  // lsbs[i] is the LSB presented in TEST of iteration i. sg_ld is Signed during LOAD and
  // sg_af is Signed elsewhere. st_test and st_done pulse Start in TEST of iteration 1 and in
  // DONE. hold keeps Start high throughout.
  task automatic run4(input logic [3:0] lsbs, input logic sg_ld, input logic sg_af,
                      input logic st_test, input logic st_done, input logic hold,
                      input logic [2:0] cprev);
    logic a, s;
    step4(1'b1, sg_af, 1'b1, {6'b000000, cprev}, "idle_start");
    step4(hold, sg_ld, 1'b1, {6'b110000, cprev}, "load");
    for (int i = 0; i < 4; i++) begin
      s = lsbs[i] && sg_ld && (i == 3);
      a = lsbs[i] && !s;
      step4(hold | (st_test && i == 1), sg_af, lsbs[i], {1'b1, 1'b0, a, s, 2'b00, 3'(i)},
            $sformatf("test%0d", i));
      step4(hold, sg_af, ~lsbs[i], {6'b100010, 3'(i)}, $sformatf("shift%0d", i));
    end
    step4(hold | st_done, sg_af, 1'b1, {6'b000001, 3'd4}, "done");
  endtask

  // ---------------------------------------------------------------- WIDTH=32 instance
  logic        start32 = 1'b0, signed32 = 1'b0;
  logic        busy32, load32, add32, sub32, shift32, done32;
  logic [5:0]  count32;
  logic [31:0] mcand_in = '0, mplier_in = '0;

  // Behavioural datapath: hi carries one guard bit so the unsigned carry and signed
  // overflow of the running sum survive until the next shift.
  logic [32:0] hi = '0;
  logic [31:0] lo = '0, mc_r = '0;
  logic        sg_r = 1'b0;
  logic [32:0] mc_ext;
  assign mc_ext = sg_r ? {mc_r[31], mc_r} : {1'b0, mc_r};

  always @(posedge clk) begin
    if (load32) begin
      hi   <= '0;
      lo   <= mplier_in;
      mc_r <= mcand_in;
      sg_r <= signed32;
    end else if (add32) begin
      hi <= hi + mc_ext;
    end else if (sub32) begin
      hi <= hi - mc_ext;
    end else if (shift32) begin
      hi <= {sg_r ? hi[32] : 1'b0, hi[32:1]};
      lo <= {hi[0], lo[31:1]};
    end
  end

  mult_control #(.WIDTH(32), .CNT_W(6)) dut32 (
    .Clk   (clk),
    .Reset (rst),
    .Start (start32),
    .Signed(signed32),
    .Lsb   (lo[0]),
    .Busy  (busy32),
    .Load  (load32),
    .Add   (add32),
    .Sub   (sub32),
    .Shift (shift32),
    .Done  (done32),
    .Count (count32)
  );

  logic [63:0] sb_q[$];
  logic [63:0] sb_e;
  int          load_cyc = 0;
  int          done_cnt = 0;

  always @(negedge clk) begin
    #1;
    if (load32) load_cyc = cyc;
    if (done32) begin
      if (sb_q.size() != 0) begin
        sb_e = sb_q.pop_front();
        check_eq("prod32", {hi[31:0], lo}, sb_e);
        // LOAD at edge 1 and DONE at edge 2*WIDTH+2 are 65 edges apart.
        check_eq("lat32", 64'(cyc - load_cyc), 64'd65);
        check_eq("cnt32", 64'(count32), 64'd32);
      end else begin
        check_eq("done32_unexpected", 64'd1, 64'd0);
      end
      done_cnt++;
    end
  end

  task automatic mul32(input logic [31:0] mc, input logic [31:0] mp, input logic sg,
                       input logic [63:0] exp);
    int  seen;
    logic ok;
    seen = done_cnt;
    ok   = 1'b0;
    sb_q.push_back(exp);
    @(negedge clk);
    mcand_in  = mc;
    mplier_in = mp;
    signed32  = sg;
    start32   = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #3;
      if (done_cnt != seen) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check_eq("mul32_timeout", 64'd0, 64'd1);
      void'(sb_q.pop_front());
    end
  endtask

  // ---------------------------------------------------------------- sequence
  logic found;

  initial begin
    #1 rst = 1'b1;
    #2;
    check_eq("rst_out4", 64'({busy4, load4, add4, sub4, shift4, done4, count4}), 64'd0);
    check_eq("rst_out32", 64'({busy32, load32, add32, sub32, shift32, done32, count32}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Unsigned, Lsb 1,0,1,1
    run4(4'b1101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    idle4(2, 3'd4);
    // Signed, Lsb 0,1,0,1: Add in iteration 1, Sub in iteration 3
    run4(4'b1010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4);
    idle4(2, 3'd4);
    // Signed in LOAD only: Sub on the final iteration is still issued
    run4(4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4);
    idle4(2, 3'd4);
    // Start pulses in TEST and DONE are ignored
    run4(4'b0110, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd4);
    idle4(3, 3'd4);
    // Start held: DONE, one IDLE cycle, then LOAD of the next operation
    run4(4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4);
    run4(4'b0101, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd4);
    idle4(2, 3'd4);
    @(negedge clk);
    #4;

    // Asynchronous reset while in SHIFT with Count=2
    found = 1'b0;
    @(negedge clk);
    start4 = 1'b1;
    lsb4   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      start4 = 1'b0;
      #3;
      if (shift4 && count4 == 3'd2) begin
        found = 1'b1;
        break;
      end
    end
    check_eq("reach_shift2", 64'(found), 64'd1);
    rst = 1'b1;
    #1;
    check_eq("rst_mid4", 64'({busy4, load4, add4, sub4, shift4, done4, count4}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run4(4'b1011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    idle4(1, 3'd4);
    @(negedge clk);
    #4;

    // Closed loop with the behavioural datapath
    mul32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    mul32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001);
    mul32(32'h8000_0000, 32'h0000_0002, 1'b1, 64'hFFFF_FFFF_0000_0000);
    mul32(32'h0000_0007, 32'h8000_0003, 1'b0, 64'h0000_0003_8000_0015);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
